// File: rtl/l2_line_mover_pkg.sv
// l2_mover_pkg: shared geometry, beat count, state and opcode types for the L2 line mover
package l2_mover_pkg;
  localparam int s_offset = 5;
  localparam int s_index = 4;
  localparam int s_beat = 64;
  localparam int s_mask = 2 ** s_offset;
  localparam int s_line = 8 * s_mask;
  function automatic int beats_of(input int line_bits, input int beat_bits);
    return line_bits / beat_bits;
  endfunction
  localparam int beats = beats_of(s_line, s_beat);
  localparam int s_cnt = $clog2(beats);
  localparam logic [31:0] align_mask = ~32'(s_mask - 1);
  typedef enum logic [2:0] {IDLE, EV_RD, EV_CAP, EV_BURST, FILL_BURST, FILL_WR, DONE} state_t;
  typedef enum logic [1:0] {OP_FILL = 2'b00, OP_EVICT = 2'b01, OP_WB_FILL = 2'b10, OP_RSVD = 2'b11} op_t;
endpackage

// File: rtl/l2_line_mover_if.sv
// l2_line_mover_if: controller request, data-array port and memory burst port; master=mover, slave=environment
interface l2_line_mover_if;
  import l2_mover_pkg::*;
  logic req_valid;
  logic [1:0] req_op;
  logic [s_index-1:0] req_index;
  logic [31:0] req_addr;
  logic [31:0] req_wb_addr;
  logic req_ready;
  logic done;
  logic [s_line-1:0] fill_line;
  logic arr_read;
  logic [s_mask-1:0] arr_write_en;
  logic [s_index-1:0] arr_rindex;
  logic [s_index-1:0] arr_windex;
  logic [s_line-1:0] arr_datain;
  logic [s_line-1:0] arr_dataout;
  logic mem_read;
  logic mem_write;
  logic [31:0] mem_address;
  logic [s_beat-1:0] mem_wdata;
  logic [s_beat-1:0] mem_rdata;
  logic mem_resp;
  modport master (
    input req_valid, req_op, req_index, req_addr, req_wb_addr, arr_dataout, mem_rdata, mem_resp,
    output req_ready, done, fill_line, arr_read, arr_write_en, arr_rindex, arr_windex, arr_datain,
      mem_read, mem_write, mem_address, mem_wdata
  );
  modport slave (
    output req_valid, req_op, req_index, req_addr, req_wb_addr, arr_dataout, mem_rdata, mem_resp,
    input req_ready, done, fill_line, arr_read, arr_write_en, arr_rindex, arr_windex, arr_datain,
      mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/l2_line_mover_buffer.sv
// l2_line_buffer: one-line register; beat write from memory, full load from array, beat read mux (clk, rst, wr_*, load*, rd_*, line)
module l2_line_buffer
  import l2_mover_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [s_cnt-1:0] wr_beat,
  input  logic [s_beat-1:0] wr_data,
  input  logic load,
  input  logic [s_line-1:0] load_data,
  input  logic [s_cnt-1:0] rd_beat,
  output logic [s_beat-1:0] rd_data,
  output logic [s_line-1:0] line
);
  always_ff @(posedge clk) begin
    if (rst) line <= '0;
    else if (load) line <= load_data;
    else if (wr_en) line[wr_beat*s_beat +: s_beat] <= wr_data;
  end
  assign rd_data = line[rd_beat*s_beat +: s_beat];
endmodule

// File: rtl/l2_line_mover.sv
// l2_line_mover: fill/evict/writeback-then-fill line engine; ports clk, rst, bus (request, array port, memory burst port)
module l2_line_mover
  import l2_mover_pkg::*;
(
  input logic clk,
  input logic rst,
  l2_line_mover_if.master bus
);
  state_t state;
  op_t op;
  logic [s_index-1:0] idx;
  logic [31:0] addr;
  logic [31:0] wb_addr;
  logic [s_cnt-1:0] k;
  logic last;
  logic [s_beat-1:0] rd_beat;
  logic [s_line-1:0] line;
  assign last = k == s_cnt'(beats - 1);
  l2_line_buffer u_buf (
    .clk(clk),
    .rst(rst),
    .wr_en(state == FILL_BURST && bus.mem_resp),
    .wr_beat(k),
    .wr_data(bus.mem_rdata),
    .load(state == EV_CAP),
    .load_data(bus.arr_dataout),
    .rd_beat(k),
    .rd_data(rd_beat),
    .line(line)
  );
  assign bus.req_ready = state == IDLE;
  assign bus.done = state == DONE;
  assign bus.arr_read = state == EV_RD;
  assign bus.arr_write_en = state == FILL_WR ? '1 : '0;
  assign bus.arr_rindex = idx;
  assign bus.arr_windex = idx;
  assign bus.arr_datain = state == FILL_WR ? line : '0;
  assign bus.mem_write = state == EV_BURST;
  assign bus.mem_read = state == FILL_BURST;
  assign bus.mem_address = state == EV_BURST ? wb_addr & align_mask :
                           state == FILL_BURST ? addr & align_mask : '0;
  assign bus.mem_wdata = bus.mem_write ? rd_beat : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= OP_FILL;
      idx <= '0;
      addr <= '0;
      wb_addr <= '0;
      k <= '0;
      bus.fill_line <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid && bus.req_op != OP_RSVD) begin
          op <= op_t'(bus.req_op);
          idx <= bus.req_index;
          addr <= bus.req_addr;
          wb_addr <= bus.req_wb_addr;
          state <= bus.req_op == OP_FILL ? FILL_BURST : EV_RD;
        end
        EV_RD: state <= EV_CAP;
        EV_CAP: state <= EV_BURST;
        EV_BURST, FILL_BURST: if (bus.mem_resp) begin
          k <= last ? '0 : k + 1'b1;
          if (last) state <= state == FILL_BURST ? FILL_WR : op == OP_WB_FILL ? FILL_BURST : DONE;
        end
        FILL_WR: begin
          bus.fill_line <= line;
          state <= DONE;
        end
        DONE: begin
          idx <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_line_mover.sv
// tb_l2_line_mover: table-driven and randomized check of l2_line_mover against a transaction-level model
module tb_l2_line_mover;
  import l2_mover_pkg::*;
  typedef struct {
    int kind;
    logic [31:0] a;
    logic [s_line-1:0] d;
  } ev_t;
  typedef struct {
    logic [1:0] op;
    logic [3:0] idx;
    logic [31:0] addr;
    logic [31:0] wb;
    int gap;
    bit noisy;
    logic [31:0] exp_rd;
    logic [31:0] exp_wb;
    int exp_lat;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  l2_line_mover_if bus();
  l2_line_mover dut (.clk(clk), .rst(rst), .bus(bus));
  logic [s_line-1:0] arr [16];
  logic [s_line-1:0] arr_q = '0;
  logic [s_line-1:0] last_fill = '0;
  ev_t act[$];
  logic [s_beat-1:0] rq[$];
  int errors = 0, checks = 0, bad = 0, bad_mask = 0, gap = 0, gcnt = 0;
  bit idle_noise = 0, pr = 0, pw = 0;
  logic [31:0] pa = '0;
  assign bus.arr_dataout = arr_q;
  always @(posedge clk) begin
    if (bus.arr_read) begin
      arr_q <= arr[bus.arr_rindex];
      act.push_back('{4, 32'(bus.arr_rindex), '0});
    end
    if (bus.arr_write_en != '0) begin
      arr[bus.arr_windex] = bus.arr_datain;
      if (bus.arr_write_en != '1) bad_mask++;
      act.push_back('{2, 32'(bus.arr_windex), bus.arr_datain});
    end
    if (bus.mem_resp && bus.mem_write) act.push_back('{0, bus.mem_address, s_line'(bus.mem_wdata)});
    if (bus.mem_resp && bus.mem_read) begin
      act.push_back('{1, bus.mem_address, s_line'(bus.mem_rdata)});
      if (rq.size() > 0) void'(rq.pop_front());
    end
    if (bus.done) act.push_back('{3, 0, '0});
  end
  always @(negedge clk) begin
    if (bus.arr_read && bus.arr_write_en != '0) bad++;
    if (bus.mem_read && bus.mem_write) bad++;
    if (((bus.mem_read && pr) || (bus.mem_write && pw)) && bus.mem_address != pa) bad++;
    pr = bus.mem_read;
    pw = bus.mem_write;
    pa = bus.mem_address;
  end
  always @(negedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      bus.mem_resp = gcnt >= gap;
      gcnt = gcnt >= gap ? 0 : gcnt + 1;
      bus.mem_rdata = rq.size() > 0 ? rq[0] : '0;
    end else begin
      bus.mem_resp = idle_noise ? 1'($urandom) : 1'b0;
      gcnt = 0;
    end
  end
  task automatic chk(input string nm, input logic [s_line-1:0] got, input logic [s_line-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic run_txn(input vec_t v, input bit rand_data);
    ev_t ex[$];
    logic [s_line-1:0] old, nl;
    logic [s_beat-1:0] b;
    int n, rdy_err;
    bit seen;
    old = arr[v.idx];
    nl = '0;
    rdy_err = 0;
    seen = 0;
    n = 1;
    @(negedge clk);
    act.delete();
    rq.delete();
    gap = v.gap;
    if (v.op == 2'b01 || v.op == 2'b10) begin
      ex.push_back('{4, 32'(v.idx), '0});
      for (int j = 0; j < beats; j++) ex.push_back('{0, v.exp_wb, s_line'(old[j*s_beat +: s_beat])});
    end
    if (v.op == 2'b00 || v.op == 2'b10) begin
      for (int j = 0; j < beats; j++) begin
        b = rand_data ? {$urandom, $urandom} : {8{8'(8'h11 * (j + 1))}};
        rq.push_back(b);
        nl[j*s_beat +: s_beat] = b;
        ex.push_back('{1, v.exp_rd, s_line'(b)});
      end
      ex.push_back('{2, 32'(v.idx), nl});
      last_fill = nl;
    end
    if (v.op != 2'b11) ex.push_back('{3, 0, '0});
    chk("ready_before", s_line'(bus.req_ready), 1);
    bus.req_valid = 1;
    bus.req_op = v.op;
    bus.req_index = v.idx;
    bus.req_addr = v.addr;
    bus.req_wb_addr = v.wb;
    if (v.op == 2'b11) begin
      repeat (8) begin
        @(posedge clk);
        @(negedge clk);
        if (!bus.req_ready || bus.done || bus.mem_read || bus.mem_write || bus.arr_read) rdy_err++;
      end
      bus.req_valid = 0;
    end else begin
      while (!seen && n < 400) begin
        @(posedge clk);
        @(negedge clk);
        n++;
        if (bus.done) begin
          seen = 1;
          bus.req_valid = 0;
        end else begin
          if (bus.req_ready) rdy_err++;
          bus.req_valid = v.noisy ? 1'($urandom) : 1'b0;
          bus.req_op = 2'($urandom);
          bus.req_index = 4'($urandom);
          bus.req_addr = $urandom;
          bus.req_wb_addr = $urandom;
        end
      end
      chk("done_seen", s_line'(seen), 1);
      if (v.exp_lat > 0) chk("latency", s_line'(n), s_line'(v.exp_lat));
    end
    chk("ready_busy", s_line'(rdy_err), 0);
    @(posedge clk);
    @(negedge clk);
    chk("ready_after", s_line'(bus.req_ready), 1);
    chk("idle_index", s_line'({bus.arr_rindex, bus.arr_windex}), 0);
    chk("ev_count", s_line'(act.size()), s_line'(ex.size()));
    for (int i = 0; i < ex.size() && i < act.size(); i++) begin
      chk($sformatf("ev%0d_kind", i), s_line'(act[i].kind), s_line'(ex[i].kind));
      chk($sformatf("ev%0d_addr", i), s_line'(act[i].a), s_line'(ex[i].a));
      chk($sformatf("ev%0d_data", i), act[i].d, ex[i].d);
    end
    chk("fill_line", bus.fill_line, last_fill);
  endtask
  task automatic reset_mid_fill();
    int n, bad_ev;
    n = 0;
    bad_ev = 0;
    @(negedge clk);
    act.delete();
    rq.delete();
    gap = 0;
    idle_noise = 0;
    for (int j = 0; j < beats; j++) rq.push_back({$urandom, $urandom});
    bus.req_valid = 1;
    bus.req_op = 2'b00;
    bus.req_index = 4'd4;
    bus.req_addr = 32'h0000_3000;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    while (rq.size() > beats - 2 && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("rst_reach_beat2", s_line'(rq.size()), s_line'(beats - 2));
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_mem_read", s_line'(bus.mem_read), 0);
    chk("rst_ready", s_line'(bus.req_ready), 1);
    chk("rst_fill_line", bus.fill_line, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    foreach (act[i]) if (act[i].kind == 2 || act[i].kind == 3) bad_ev++;
    chk("rst_no_write", s_line'(bad_ev), 0);
    last_fill = '0;
    rq.delete();
  endtask
  vec_t vecs[6];
  vec_t rv;
  initial begin
    bus.req_valid = 0;
    bus.req_op = 0;
    bus.req_index = 0;
    bus.req_addr = 0;
    bus.req_wb_addr = 0;
    bus.mem_resp = 0;
    bus.mem_rdata = 0;
    for (int i = 0; i < 16; i++) arr[i] = {8{$urandom}};
    arr[5] = {64'hDEAD_0004_0000_BEEF, 64'hDEAD_0003_0000_BEEF, 64'hDEAD_0002_0000_BEEF, 64'hDEAD_0001_0000_BEEF};
    vecs[0] = '{2'b00, 4'd3, 32'h1234_5678, 32'h0, 0, 0, 32'h1234_5660, 32'h0, beats + 3};
    vecs[1] = '{2'b01, 4'd5, 32'h0, 32'h0000_0040, 0, 0, 32'h0, 32'h0000_0040, beats + 4};
    vecs[2] = '{2'b10, 4'd7, 32'h0000_1000, 32'h0000_203F, 0, 0, 32'h0000_1000, 32'h0000_2020, 2 * beats + 5};
    vecs[3] = '{2'b00, 4'd9, 32'hFFFF_FFFF, 32'h0, 2, 1, 32'hFFFF_FFE0, 32'h0, 0};
    vecs[4] = '{2'b11, 4'd2, 32'h0000_0100, 32'h0000_0200, 0, 0, 32'h0, 32'h0, 0};
    vecs[5] = '{2'b10, 4'd15, 32'h8000_001F, 32'h7FFF_FFE1, 1, 1, 32'h8000_0000, 32'h7FFF_FFE0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", s_line'(bus.req_ready), 1);
    chk("rst_done", s_line'(bus.done), 0);
    chk("rst_mem_rw", s_line'({bus.mem_read, bus.mem_write, bus.arr_read}), 0);
    chk("rst_arr_we", s_line'(bus.arr_write_en), 0);
    chk("rst_mem_addr", s_line'(bus.mem_address), 0);
    chk("rst_wdata", s_line'(bus.mem_wdata), 0);
    chk("rst_index", s_line'({bus.arr_rindex, bus.arr_windex}), 0);
    chk("rst_fill", bus.fill_line, 0);
    rst = 0;
    foreach (vecs[i]) run_txn(vecs[i], i > 2);
    reset_mid_fill();
    idle_noise = 1;
    for (int i = 0; i < 25; i++) begin
      rv.op = 2'($urandom);
      rv.idx = 4'($urandom);
      rv.addr = $urandom;
      rv.wb = $urandom;
      rv.gap = $urandom_range(0, 3);
      rv.noisy = 1'($urandom);
      rv.exp_rd = rv.addr - rv.addr % s_mask;
      rv.exp_wb = rv.wb - rv.wb % s_mask;
      rv.exp_lat = rv.gap != 0 ? 0 : rv.op == 2'b00 ? beats + 3 : rv.op == 2'b01 ? beats + 4 :
                   rv.op == 2'b10 ? 2 * beats + 5 : 0;
      run_txn(rv, 1);
    end
    chk("protocol", s_line'(bad), 0);
    chk("write_mask", s_line'(bad_mask), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
